// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// reset PC, FSM state encoding and PC update operations.
package fetch_unit_pkg;

  localparam int         ADDR_W_DEF   = 8;
  localparam int         DATA_W_DEF   = 8;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_op_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's program-memory, instruction-register and
// decode-control signals; master is the fetch unit, slave its surroundings.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [DATA_W-1:0] memData;
  logic              irWriteEn;
  logic [DATA_W-1:0] irData;
  logic              irValid;
  logic              nextReady;
  logic              jumpEn;
  logic [ADDR_W-1:0] jumpAddr;
  logic              halt;
  logic [ADDR_W-1:0] pcOut;

  modport master (
    output memReq, memAddr, irWriteEn, irData, irValid, pcOut,
    input  memAck, memData, nextReady, jumpEn, jumpAddr, halt
  );

  modport slave (
    input  memReq, memAddr, irWriteEn, irData, irValid, pcOut,
    output memAck, memData, nextReady, jumpEn, jumpAddr, halt
  );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: loads a jump target, increments after a fetch
// (wrapping at the top of the address space) or holds its value.
module fetch_unit_pc_counter
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              resetN,
  input  pc_op_t            op,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc <= RESET_PC;
    end else begin
      case (op)
        PC_INC:  pc <= pc + ADDR_W'(1);
        PC_LOAD: pc <= load_val;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory over a req/ack
// handshake and hands each byte to the instruction register until decode is ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic         clk,
  input  logic         resetN,
  fetch_unit_if.master bus
);

  state_t            state, state_nxt;
  pc_op_t            pc_op;
  logic [ADDR_W-1:0] pc, pc_load_val;

  logic [DATA_W-1:0] ir_data;
  logic              ir_write_en, ir_capture;

  logic              jump_pend, jump_pend_nxt;
  logic [ADDR_W-1:0] jump_tgt, jump_tgt_nxt;
  logic              halt_pend, halt_pend_nxt;

  logic              jump_take, halt_take;
  logic [ADDR_W-1:0] jump_sel;

  fetch_unit_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .resetN   (resetN),
    .op       (pc_op),
    .load_val (pc_load_val),
    .pc       (pc)
  );

  // A jump arriving on the ack edge itself wins over an older pending target.
  assign jump_take = jump_pend || bus.jumpEn;
  assign halt_take = halt_pend || bus.halt;
  assign jump_sel  = bus.jumpEn ? bus.jumpAddr : jump_tgt;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    pc_op         = PC_HOLD;
    pc_load_val   = bus.jumpAddr;
    ir_capture    = 1'b0;
    jump_pend_nxt = jump_pend;
    jump_tgt_nxt  = jump_tgt;
    halt_pend_nxt = halt_pend;

    case (state)
      S_IDLE: state_nxt = S_REQ;

      S_REQ: begin
        if (bus.memAck) begin
          jump_pend_nxt = 1'b0;
          halt_pend_nxt = 1'b0;
          if (halt_take) begin
            // Halt lets the in-flight fetch land normally; a pending jump is dropped.
            pc_op      = PC_INC;
            ir_capture = 1'b1;
            state_nxt  = S_HALT;
          end else if (jump_take) begin
            pc_op       = PC_LOAD;
            pc_load_val = jump_sel;
          end else begin
            pc_op      = PC_INC;
            ir_capture = 1'b1;
            state_nxt  = S_HOLD;
          end
        end else begin
          if (bus.jumpEn) begin
            jump_pend_nxt = 1'b1;
            jump_tgt_nxt  = bus.jumpAddr;
          end
          if (bus.halt) begin
            halt_pend_nxt = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (bus.halt) begin
          state_nxt = S_HALT;
        end else if (bus.jumpEn) begin
          pc_op = PC_LOAD;
          if (bus.nextReady) begin
            state_nxt = S_REQ;
          end
        end else if (bus.nextReady) begin
          state_nxt = S_REQ;
        end
      end

      S_HALT: state_nxt = S_HALT;

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      ir_data     <= '0;
      ir_write_en <= 1'b0;
      jump_pend   <= 1'b0;
      jump_tgt    <= '0;
      halt_pend   <= 1'b0;
    end else begin
      state       <= state_nxt;
      ir_write_en <= ir_capture;
      if (ir_capture) begin
        ir_data <= bus.memData;
      end
      jump_pend   <= jump_pend_nxt;
      jump_tgt    <= jump_tgt_nxt;
      halt_pend   <= halt_pend_nxt;
    end
  end

  assign bus.memReq    = (state == S_REQ);
  assign bus.memAddr   = pc;
  assign bus.irWriteEn = ir_write_en;
  assign bus.irData    = ir_data;
  assign bus.irValid   = (state == S_HOLD);
  assign bus.pcOut     = pc;

endmodule
